reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_read_port.sv | 22 ++
 rtl/reg_file.sv | 85 ++++++++
 tb/tb_reg_file.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared CPU definitions for the register file: default widths and named register indices.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port with optional same-cycle write forwarding.
module reg_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                    idx,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs,
  input  logic                                 byp_en,
  input  logic [ADDR_W-1:0]                    byp_idx,
  input  logic [DATA_W-1:0]                    byp_data,
  output logic [DATA_W-1:0]                    data
);

  // NOTE: data gets a default before the conditional override; without it the
  // incomplete if would infer a latch.
  always_comb begin
    data = regs[idx];
    if (BYPASS != 0 && byp_en && byp_idx == idx) data = byp_data;
  end

endmodule

// File: rtl/reg_file.sv
// CPU register file: two combinational read ports, one write port, registered debug
// port and saturating write-activity counters. Register 0 reads as zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count,
  output logic [ADDR_W-1:0] last_wr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]                regs_q [1:DEPTH-1];
  logic [DEPTH-1:0][DATA_W-1:0]     regs_view;
  logic                             wr_en;
  logic                             byp_en;

  assign wr_en  = reg_write && (write_reg != ADDR_W'(REG_ZERO));
  // Forwarding is suppressed during reset so reads stay zero while rst_n is low.
  assign byp_en = rst_n && wr_en;

  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) regs_view[i] = regs_q[i];
  end

  // NOTE: every storage entry is cleared on reset because software may read a
  // register before writing it and must see zero, not power-up garbage.
  // NOTE: sequential state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      last_wr  <= '0;
      dbg_data <= '0;
    end else begin
      dbg_data <= regs_view[dbg_addr];
      if (wr_en) begin
        last_wr <= write_reg;
        if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port1 (
    .idx      (read_reg1),
    .regs     (regs_view),
    .byp_en   (byp_en),
    .byp_idx  (write_reg),
    .byp_data (write_data),
    .data     (read_data1)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port2 (
    .idx      (read_reg2),
    .regs     (regs_view),
    .byp_en   (byp_en),
    .byp_idx  (write_reg),
    .byp_data (write_data),
    .data     (read_data2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a forwarding instance (CNT_W=4) and a
// non-forwarding instance (CNT_W=16) share one stimulus stream.
module tb_reg_file;
  import reg_file_pkg::*;

  typedef enum int {RD1, RD2, DBG, CNT, LAST, RD1_NB, RD2_NB, CNT_NB, DBG_NB, LAST_NB} obs_e;
  typedef struct {
    int          tag;
    obs_e        which;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
  logic        reg_write;
  logic [31:0] write_data;
  logic [31:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;
  logic [4:0]  last_a, last_b;

  sb_entry_t sb[$];
  int n_neg = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_a), .read_data2(rd2_a), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_a), .wr_count(cnt_a), .last_wr(last_a)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(16)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b), .read_data2(rd2_b), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_b), .wr_count(cnt_b), .last_wr(last_b)
  );

  function automatic logic [31:0] observe(obs_e w);
    case (w)
      RD1:     return rd1_a;
      RD2:     return rd2_a;
      DBG:     return dbg_a;
      CNT:     return 32'(cnt_a);
      LAST:    return 32'(last_a);
      RD1_NB:  return rd1_b;
      RD2_NB:  return rd2_b;
      CNT_NB:  return 32'(cnt_b);
      DBG_NB:  return dbg_b;
      default: return 32'(last_b);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    n_neg++;
    while (sb.size() > 0 && sb[0].tag <= n_neg) begin
      sb_entry_t e;
      e = sb.pop_front();
      check(e.name, observe(e.which), e.exp);
    end
  end

  // Expectations apply to the next falling edge after the current drive point.
  task automatic expect_obs(input obs_e w, input logic [31:0] exp, input string name);
    sb_entry_t e;
    e.tag = n_neg + 1;
    e.which = w;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    reg_write = we;
    write_reg = wr;
    write_data = wd;
    read_reg1 = r1;
    read_reg2 = r2;
  endtask

  initial begin
    rst_n = 1'b0;
    dbg_addr = 5'd0;
    drive(1'b1, 5'd8, 32'hAAAA_AAAA, 5'd8, 5'd31);
    step();
    step();
    // Reset held while a write is driven: nothing visible, nothing counted.
    expect_obs(RD1, 32'h0, "reset_rd1_bypass_gated");
    expect_obs(RD2, 32'h0, "reset_rd2");
    expect_obs(DBG, 32'h0, "reset_dbg");
    expect_obs(CNT, 32'h0, "reset_cnt");
    expect_obs(LAST, 32'h0, "reset_last");
    expect_obs(RD1_NB, 32'h0, "reset_rd1_nb");

    step();
    rst_n = 1'b1;
    drive(1'b1, 5'd8, 32'h1234_5678, 5'd3, 5'd0);
    expect_obs(RD1, 32'h0, "unwritten_r3");
    expect_obs(RD2, 32'h0, "r0_idle");

    step();
    drive(1'b0, 5'd8, 32'h0, 5'd8, 5'd0);
    dbg_addr = 5'd8;
    expect_obs(RD1, 32'h1234_5678, "write_read_r8");
    expect_obs(RD1_NB, 32'h1234_5678, "write_read_r8_nb");
    expect_obs(CNT, 32'd1, "cnt_after_first");
    expect_obs(LAST, 32'd8, "last_after_first");
    expect_obs(DBG, 32'h0, "dbg_r0");

    step();
    drive(1'b1, 5'(REG_ZERO), 32'hFFFF_FFFF, 5'd0, 5'd0);
    expect_obs(RD1, 32'h0, "r0_write_rd1");
    expect_obs(RD2, 32'h0, "r0_write_rd2");
    expect_obs(DBG, 32'h1234_5678, "dbg_r8_latency");
    expect_obs(DBG_NB, 32'h1234_5678, "dbg_r8_nb");

    step();
    drive(1'b1, 5'd9, 32'd5, 5'd8, 5'd8);
    expect_obs(CNT, 32'd1, "r0_write_not_counted");
    expect_obs(LAST, 32'd8, "r0_write_last_hold");
    expect_obs(RD2, 32'h1234_5678, "both_ports_r8");

    step();
    drive(1'b1, 5'd9, 32'd7, 5'd9, 5'd9);
    expect_obs(RD1, 32'd7, "bypass_rd1");
    expect_obs(RD2, 32'd7, "bypass_rd2");
    expect_obs(RD1_NB, 32'd5, "nobypass_rd1_old");
    expect_obs(RD2_NB, 32'd5, "nobypass_rd2_old");
    expect_obs(CNT, 32'd2, "cnt_two");

    step();
    drive(1'b0, 5'd9, 32'd0, 5'd9, 5'd9);
    expect_obs(RD1, 32'd7, "r9_after_write");
    expect_obs(RD1_NB, 32'd7, "nobypass_rd1_new");
    expect_obs(RD2_NB, 32'd7, "nobypass_rd2_new");
    expect_obs(LAST, 32'd9, "last_r9");
    expect_obs(LAST_NB, 32'd9, "last_r9_nb");

    step();
    drive(1'b1, 5'(REG_SP), 32'hDEAD_BEEF, 5'(REG_SP), 5'(REG_RA));
    expect_obs(RD1, 32'hDEAD_BEEF, "bypass_sp");
    expect_obs(RD2, 32'h0, "ra_unwritten");
    expect_obs(CNT, 32'd3, "cnt_three");

    // Twenty writes to r31; the 4-bit counter stops at 15, the 16-bit one keeps going.
    for (int i = 0; i < 20; i++) begin
      step();
      drive(1'b1, 5'(REG_RA), 32'(100 + i), 5'd0, 5'd0);
      expect_obs(CNT, (4 + i > 15) ? 32'd15 : 32'(4 + i), "cnt_sat_walk");
      expect_obs(CNT_NB, 32'(4 + i), "cnt_wide_walk");
    end

    step();
    drive(1'b0, 5'd0, 32'h0, 5'(REG_RA), 5'(REG_SP));
    dbg_addr = 5'(REG_RA);
    expect_obs(CNT, 32'd15, "cnt_saturated");
    expect_obs(CNT_NB, 32'd24, "cnt_wide_final");
    expect_obs(RD1, 32'd119, "ra_last_value");
    expect_obs(RD2, 32'hDEAD_BEEF, "sp_value");
    expect_obs(LAST, 32'd31, "last_ra");

    step();
    expect_obs(DBG, 32'd119, "dbg_ra");

    // Asynchronous reset between edges while a write is pending.
    step();
    drive(1'b1, 5'd5, 32'h55, 5'(REG_RA), 5'd5);
    expect_obs(RD1, 32'h0, "async_rst_rd1");
    expect_obs(RD2, 32'h0, "async_rst_bypass_gated");
    expect_obs(CNT, 32'h0, "async_rst_cnt");
    expect_obs(LAST, 32'h0, "async_rst_last");
    expect_obs(DBG, 32'h0, "async_rst_dbg");
    #3 rst_n = 1'b0;

    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd8);
    expect_obs(RD1, 32'h0, "no_commit_in_reset");
    expect_obs(RD2, 32'h0, "r8_cleared");
    expect_obs(CNT, 32'h0, "cnt_still_zero");
    expect_obs(CNT_NB, 32'h0, "cnt_nb_still_zero");

    step();
    drive(1'b0, 5'd8, 32'hxxxx_xxxx, 5'd0, 5'd8);

    step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
    expect_obs(RD2, 32'h0, "x_data_no_write");
    expect_obs(CNT, 32'h0, "x_data_no_count");

    repeat (3) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
